// File: rtl/std_cache_pkg.sv
// Shared dcache/store-buffer types: the cache port request/response structs and the
// committed-store entry and drain-state encodings used by std_store_buffer.
package std_cache_pkg;

  localparam int unsigned SB_DEPTH           = 8;
  localparam int unsigned SB_PADDR_WIDTH     = 56;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = SB_PADDR_WIDTH - DCACHE_INDEX_WIDTH;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic [SB_PADDR_WIDTH-1:0] paddr;
    logic [63:0]               data;
    logic [7:0]                be;
    logic [1:0]                size;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TAG  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_match.sv
// Load-vs-buffered-store compare: per-entry doubleword/byte-overlap conflict, plus the
// youngest-hit forwarding select that exists only when STD_STORE_BUF_FWD_EN is defined.
module sb_match #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW_W  = 53
) (
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [$clog2(DEPTH):0]     count_i,
  input  logic [DEPTH-1:0][DW_W-1:0] dw_i,
  input  logic [DEPTH-1:0][7:0]      be_i,
  input  logic [DEPTH-1:0][63:0]     data_i,
  input  logic [DW_W-1:0]            ld_dw_i,
  input  logic [7:0]                 ld_be_i,
  output logic                       conflict_o,
  output logic                       fwd_valid_o,
  output logic [63:0]                fwd_data_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] dw_hit;
  logic [DEPTH-1:0] overlap;
  logic [PTR_W-1:0] age;

  // A slot is live when its age relative to head is below the occupancy count.
  always_comb begin
    dw_hit  = '0;
    overlap = '0;
    age     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age        = PTR_W'(i) - head_i;
      dw_hit[i]  = (CNT_W'(age) < count_i) && (dw_i[i] == ld_dw_i);
      overlap[i] = dw_hit[i] && ((be_i[i] & ld_be_i) != 8'h00);
    end
  end

  assign conflict_o = |overlap;

`ifdef STD_STORE_BUF_FWD_EN
  logic [PTR_W-1:0] yng_idx;
  logic [PTR_W-1:0] idx;
  logic             yng_hit;

  // Walk oldest to youngest; the last live doubleword hit wins.
  always_comb begin
    yng_hit = 1'b0;
    yng_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (dw_hit[idx]) begin
        yng_hit = 1'b1;
        yng_idx = idx;
      end
    end
  end

  assign fwd_valid_o = yng_hit && ((be_i[yng_idx] & ld_be_i) == ld_be_i) && (ld_be_i != 8'h00);
  assign fwd_data_o  = fwd_valid_o ? data_i[yng_idx] : 64'h0;
`else
  logic unused_data_w;
  assign unused_data_w = ^data_i;
  assign fwd_valid_o   = 1'b0;
  assign fwd_data_o    = 64'h0;
`endif

endmodule

// File: rtl/std_store_buffer.sv
// Committed-store FIFO ahead of the dcache store port; drains oldest-first via index/grant/tag.
// Define STD_STORE_BUF_FWD_EN to build store-to-load forwarding from the youngest matching entry.
module std_store_buffer
  import std_cache_pkg::*;
#(
  parameter int unsigned DEPTH       = SB_DEPTH,
  parameter int unsigned PADDR_WIDTH = SB_PADDR_WIDTH,
  parameter int unsigned INDEX_WIDTH = DCACHE_INDEX_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [PADDR_WIDTH-1:0] push_paddr_i,
  input  logic [63:0]            push_data_i,
  input  logic [7:0]             push_be_i,
  input  logic [1:0]             push_size_i,
  input  logic [PADDR_WIDTH-1:0] ld_paddr_i,
  input  logic [7:0]             ld_be_i,
  output logic                   ld_conflict_o,
  output logic                   ld_fwd_valid_o,
  output logic [63:0]            ld_fwd_data_o,
  output logic                   empty_o,
  output dcache_req_i_t          dcache_req_o,
  input  dcache_req_o_t          dcache_rsp_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DW_W  = PADDR_WIDTH - 3;

  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        push_ent;
  sb_entry_t        head_ent;
  sb_state_e        state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_fire;
  logic             pop;

  logic [DEPTH-1:0][DW_W-1:0] ent_dw;
  logic [DEPTH-1:0][7:0]      ent_be;
  logic [DEPTH-1:0][63:0]     ent_data;

  logic unused_rsp_w;
  assign unused_rsp_w = ^{dcache_rsp_i.data_rvalid, dcache_rsp_i.data_rdata};

  // Ready depends only on the registered count, never on the cache grant.
  assign push_ready_o = (count_q != CNT_W'(DEPTH));
  assign push_fire    = push_valid_i & push_ready_o;
  assign pop          = (state_q == TAG);
  assign empty_o      = (count_q == '0) && (state_q == IDLE);
  assign head_ent     = mem_q[head_q];

  always_comb begin
    push_ent       = '0;
    push_ent.paddr = SB_PADDR_WIDTH'(push_paddr_i);
    push_ent.data  = push_data_i;
    push_ent.be    = push_be_i;
    push_ent.size  = push_size_i;
  end

  // Storage is not reset; occupancy is tracked solely by head/count.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[tail_q] <= push_ent;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Drain FSM next-state and cache request; clear overrides everything.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q + CNT_W'(push_fire) - CNT_W'(pop);
    dcache_req_o = '0;
    if (push_fire) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = REQ;
        end
      end
      REQ: begin
        dcache_req_o.data_req      = 1'b1;
        dcache_req_o.data_we       = 1'b1;
        dcache_req_o.address_index = DCACHE_INDEX_WIDTH'(head_ent.paddr[INDEX_WIDTH-1:0]);
        dcache_req_o.data_wdata    = head_ent.data;
        dcache_req_o.data_be       = head_ent.be;
        dcache_req_o.data_size     = head_ent.size;
        if (dcache_rsp_i.data_gnt) begin
          state_d = TAG;
        end
      end
      TAG: begin
        dcache_req_o.tag_valid   = 1'b1;
        dcache_req_o.address_tag = DCACHE_TAG_WIDTH'(head_ent.paddr >> INDEX_WIDTH);
        state_d                  = (count_d != '0) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_i) begin
      state_d = IDLE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_dw[i]   = DW_W'(mem_q[i].paddr >> 3);
      ent_be[i]   = mem_q[i].be;
      ent_data[i] = mem_q[i].data;
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .DW_W  (DW_W)
  ) u_sb_match (
    .head_i      (head_q),
    .count_i     (count_q),
    .dw_i        (ent_dw),
    .be_i        (ent_be),
    .data_i      (ent_data),
    .ld_dw_i     (DW_W'(ld_paddr_i >> 3)),
    .ld_be_i     (ld_be_i),
    .conflict_o  (ld_conflict_o),
    .fwd_valid_o (ld_fwd_valid_o),
    .fwd_data_o  (ld_fwd_data_o)
  );

endmodule

// File: tb/tb_std_store_buffer.sv
// Directed bench for std_store_buffer: drain protocol, full boundary, conflict/forwarding,
// push/pop overlap, wrap-around ordering, clear and asynchronous reset.
module tb_std_store_buffer;
  import std_cache_pkg::*;

  localparam int unsigned PW = 56;
`ifdef STD_STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clr_i;
  logic          push_valid_i;
  logic          push_ready_o;
  logic [PW-1:0] push_paddr_i;
  logic [63:0]   push_data_i;
  logic [7:0]    push_be_i;
  logic [1:0]    push_size_i;
  logic [PW-1:0] ld_paddr_i;
  logic [7:0]    ld_be_i;
  logic          ld_conflict_o;
  logic          ld_fwd_valid_o;
  logic [63:0]   ld_fwd_data_o;
  logic          empty_o;
  dcache_req_i_t dcache_req_o;
  dcache_req_o_t dcache_rsp_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  std_store_buffer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clr_i          (clr_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_paddr_i   (push_paddr_i),
    .push_data_i    (push_data_i),
    .push_be_i      (push_be_i),
    .push_size_i    (push_size_i),
    .ld_paddr_i     (ld_paddr_i),
    .ld_be_i        (ld_be_i),
    .ld_conflict_o  (ld_conflict_o),
    .ld_fwd_valid_o (ld_fwd_valid_o),
    .ld_fwd_data_o  (ld_fwd_data_o),
    .empty_o        (empty_o),
    .dcache_req_o   (dcache_req_o),
    .dcache_rsp_i   (dcache_rsp_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [PW-1:0] pa, input logic [63:0] d, input logic [7:0] be);
    push_valid_i = 1'b1;
    push_paddr_i = pa;
    push_data_i  = d;
    push_be_i    = be;
    push_size_i  = 2'd3;
    tick();
    push_valid_i = 1'b0;
  endtask

  // Waits (bounded) for the request phase, grants it, and returns in the TAG cycle.
  task automatic drain_one(input string tag, input logic [PW-1:0] pa, input logic [63:0] d);
    int n = 0;
    while (dcache_req_o.data_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 64'(dcache_req_o.data_req), 64'd1);
    chk({tag, "_idx"}, 64'(dcache_req_o.address_index), 64'(pa[11:0]));
    chk({tag, "_data"}, dcache_req_o.data_wdata, d);
    dcache_rsp_i.data_gnt = 1'b1;
    tick();
    dcache_rsp_i.data_gnt = 1'b0;
    chk({tag, "_tagv"}, 64'(dcache_req_o.tag_valid), 64'd1);
    chk({tag, "_tag"}, 64'(dcache_req_o.address_tag), 64'(pa >> 12));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    clr_i        = 1'b0;
    push_valid_i = 1'b0;
    push_paddr_i = '0;
    push_data_i  = '0;
    push_be_i    = '0;
    push_size_i  = '0;
    ld_paddr_i   = '0;
    ld_be_i      = '0;
    dcache_rsp_i = '0;
    tick();
    tick();

    chk("rst_ready", 64'(push_ready_o), 64'd1);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_conflict", 64'(ld_conflict_o), 64'd0);
    chk("rst_fwd_valid", 64'(ld_fwd_valid_o), 64'd0);
    chk("rst_fwd_data", ld_fwd_data_o, 64'd0);
    chk("rst_req", 64'(dcache_req_o.data_req), 64'd0);
    chk("rst_tagv", 64'(dcache_req_o.tag_valid), 64'd0);
    chk("rst_idx", 64'(dcache_req_o.address_index), 64'd0);
    chk("rst_wdata", dcache_req_o.data_wdata, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Single store, grant on the third REQ cycle.
    push(56'h8000_1008, 64'hDEAD_BEEF_0000_1111, 8'hFF);
    chk("single_notempty", 64'(empty_o), 64'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("single_req", 64'(dcache_req_o.data_req), 64'd1);
      chk("single_we", 64'(dcache_req_o.data_we), 64'd1);
      chk("single_kill", 64'(dcache_req_o.kill_req), 64'd0);
      chk("single_idx", 64'(dcache_req_o.address_index), 64'h008);
      chk("single_data", dcache_req_o.data_wdata, 64'hDEAD_BEEF_0000_1111);
      chk("single_be", 64'(dcache_req_o.data_be), 64'hFF);
      if (c == 2) dcache_rsp_i.data_gnt = 1'b1;
      else tick();
    end
    tick();
    dcache_rsp_i.data_gnt = 1'b0;
    chk("single_tagv", 64'(dcache_req_o.tag_valid), 64'd1);
    chk("single_tag", 64'(dcache_req_o.address_tag), 64'h8000_1);
    chk("single_tag_noreq", 64'(dcache_req_o.data_req), 64'd0);
    tick();
    chk("single_empty", 64'(empty_o), 64'd1);
    chk("single_tag_done", 64'(dcache_req_o.tag_valid), 64'd0);

    // Fill to DEPTH with the grant held low.
    for (int k = 0; k < 8; k++) push(56'(32'h1000 + k * 8), 64'(32'hF000 + k), 8'hFF);
    chk("fill_full", 64'(push_ready_o), 64'd0);
    push(56'h9990, 64'hBAD, 8'hFF);
    chk("fill_blocked", 64'(push_ready_o), 64'd0);
    drain_one("fill0", 56'h1000, 64'hF000);
    chk("fill_ready_in_tag", 64'(push_ready_o), 64'd0);
    tick();
    chk("fill_ready_after_tag", 64'(push_ready_o), 64'd1);
    for (int k = 1; k < 8; k++) drain_one("fill", 56'(32'h1000 + k * 8), 64'(32'hF000 + k));
    tick();
    chk("fill_empty", 64'(empty_o), 64'd1);

    // Conflict: byte-overlap within the same doubleword only.
    push(56'h100, 64'h1, 8'h0F);
    ld_paddr_i = 56'h100; ld_be_i = 8'hF0; #1;
    chk("cf_disjoint_be", 64'(ld_conflict_o), 64'd0);
    ld_be_i = 8'h01; #1;
    chk("cf_overlap", 64'(ld_conflict_o), 64'd1);
    ld_paddr_i = 56'h108; ld_be_i = 8'hFF; #1;
    chk("cf_other_dw", 64'(ld_conflict_o), 64'd0);
    push_valid_i = 1'b1; push_paddr_i = 56'h108; push_data_i = 64'h2; push_be_i = 8'hFF;
    ld_be_i = 8'h01; #1;
    chk("cf_push_same_cycle", 64'(ld_conflict_o), 64'd0);
    tick();
    push_valid_i = 1'b0;
    chk("cf_push_next_cycle", 64'(ld_conflict_o), 64'd1);
    drain_one("cf0", 56'h100, 64'h1);
    drain_one("cf1", 56'h108, 64'h2);
    tick();
    chk("cf_empty", 64'(empty_o), 64'd1);
    chk("cf_empty_noconflict", 64'(ld_conflict_o), 64'd0);

    // Forwarding from the youngest matching entry.
    push(56'h200, 64'hAAAA_0000_0000_000A, 8'hFF);
    push(56'h200, 64'hBBBB_0000_0000_000B, 8'hFF);
    ld_paddr_i = 56'h200; ld_be_i = 8'hFF; #1;
    chk("fwd_conflict", 64'(ld_conflict_o), 64'd1);
    chk("fwd_valid", 64'(ld_fwd_valid_o), FWD ? 64'd1 : 64'd0);
    chk("fwd_data_youngest", ld_fwd_data_o, FWD ? 64'hBBBB_0000_0000_000B : 64'd0);
    push(56'h200, 64'hCCCC_0000_0000_000C, 8'h0F);
    chk("fwd_partial_conflict", 64'(ld_conflict_o), 64'd1);
    chk("fwd_partial_valid", 64'(ld_fwd_valid_o), 64'd0);
    ld_be_i = 8'h03; #1;
    chk("fwd_sub_valid", 64'(ld_fwd_valid_o), FWD ? 64'd1 : 64'd0);
    chk("fwd_sub_data", ld_fwd_data_o, FWD ? 64'hCCCC_0000_0000_000C : 64'd0);
    ld_be_i = 8'h00;
    drain_one("fwd0", 56'h200, 64'hAAAA_0000_0000_000A);
    drain_one("fwd1", 56'h200, 64'hBBBB_0000_0000_000B);
    drain_one("fwd2", 56'h200, 64'hCCCC_0000_0000_000C);
    tick();
    chk("fwd_empty", 64'(empty_o), 64'd1);

    // Push and pop in the same TAG cycle at count 3.
    for (int k = 0; k < 3; k++) push(56'(32'h300 + k * 8), 64'(32'h30 + k), 8'hFF);
    drain_one("pp0", 56'h300, 64'h30);
    push(56'h318, 64'h33, 8'hFF);
    chk("pp_req_after", 64'(dcache_req_o.data_req), 64'd1);
    chk("pp_head", dcache_req_o.data_wdata, 64'h31);
    chk("pp_ready", 64'(push_ready_o), 64'd1);
    for (int k = 1; k < 4; k++) drain_one("pp", 56'(32'h300 + k * 8), 64'(32'h30 + k));
    tick();
    chk("pp_empty", 64'(empty_o), 64'd1);

    // 20 stores through the ring: ordering survives pointer wrap.
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 5; j++) push(56'(32'h4000 + (b * 5 + j) * 8), 64'(32'h5000 + b * 5 + j), 8'hFF);
      for (int j = 0; j < 5; j++) drain_one("wrap", 56'(32'h4000 + (b * 5 + j) * 8), 64'(32'h5000 + b * 5 + j));
      tick();
      chk("wrap_empty", 64'(empty_o), 64'd1);
    end

    // Clear while requesting with 5 entries.
    for (int k = 0; k < 5; k++) push(56'(32'h600 + k * 8), 64'(32'h60 + k), 8'hFF);
    chk("clr_pre_req", 64'(dcache_req_o.data_req), 64'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_req", 64'(dcache_req_o.data_req), 64'd0);
    chk("clr_empty", 64'(empty_o), 64'd1);
    chk("clr_ready", 64'(push_ready_o), 64'd1);
    ld_paddr_i = 56'h600; ld_be_i = 8'hFF; #1;
    chk("clr_conflict", 64'(ld_conflict_o), 64'd0);
    ld_be_i = 8'h00;
    tick();
    chk("clr_stays_idle", 64'(dcache_req_o.data_req), 64'd0);

    // Asynchronous reset in the TAG cycle.
    push(56'h700, 64'h70, 8'hFF);
    push(56'h708, 64'h71, 8'hFF);
    drain_one("ar0", 56'h700, 64'h70);
    #1 rst_ni = 1'b0;
    #1;
    chk("ar_req", 64'(dcache_req_o.data_req), 64'd0);
    chk("ar_tagv", 64'(dcache_req_o.tag_valid), 64'd0);
    chk("ar_empty", 64'(empty_o), 64'd1);
    chk("ar_ready", 64'(push_ready_o), 64'd1);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("ar_post_empty", 64'(empty_o), 64'd1);
    push(56'h800, 64'h80, 8'hFF);
    drain_one("ar_post", 56'h800, 64'h80);
    tick();
    chk("ar_post_drained", 64'(empty_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
